// File: rtl/lsu_mem_bridge.sv
// Load/store bridge between the core memory stage and a word-addressed memory.
// One request in flight; lane extraction, sign/zero extension and byte strobes.
module lsu_mem_bridge #(
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // state | meaning
    // IDLE  | ready for a request
    // RD    | mem_re asserted for one cycle
    // WAIT  | read latency countdown, data sampled on terminal count
    // WR    | mem_we/mem_wstrb asserted for one cycle
    // RESP  | one-cycle rsp_valid pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

    state_t      state, state_nxt;
    logic        hold;
    logic        accept;
    logic        legal;
    logic [1:0]  dec_err;
    logic [3:0]  dec_strb;
    logic [31:0] dec_wdata;
    logic [1:0]  lane;
    logic [2:0]  funct3_q;
    logic [3:0]  strb_q;
    logic [1:0]  wait_cnt;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        unused_addr_hi;

    // Upper byte-address bits fall outside the memory and simply wrap.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign accept = req_valid && req_ready;

    always_comb begin
        legal     = 1'b0;
        dec_err   = 2'd0;
        dec_strb  = 4'b1111;
        dec_wdata = req_wdata;
        if (req_we) begin
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        if (!legal) begin
            dec_err = 2'd2;
        end else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)) begin
            dec_err = 2'd1;
        end
        case (req_funct3[1:0])
            2'b00: begin
                dec_strb  = 4'b0001 << req_addr[1:0];
                dec_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                dec_strb  = req_addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                dec_strb  = 4'b1111;
                dec_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {lane, 3'b000};
        ld_byte = shifted[7:0];
        ld_half = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (dec_err != 2'd0) state_nxt = S_RESP;
                    else if (req_we)     state_nxt = S_WR;
                    else                 state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = S_WAIT;
            S_WAIT:  if (wait_cnt == 2'd0) state_nxt = S_RESP;
            S_WR:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign req_ready = (state == S_IDLE) && !hold;
    assign mem_re    = (state == S_RD);
    assign mem_we    = (state == S_WR);
    assign mem_wstrb = (state == S_WR) ? strb_q : 4'b0000;
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            hold      <= 1'b1;
            mem_addr  <= '0;
            lane      <= 2'b00;
            funct3_q  <= 3'b000;
            strb_q    <= 4'b0000;
            mem_wdata <= 32'h0;
            wait_cnt  <= 2'd0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 2'd0;
        end else begin
            state <= state_nxt;
            hold  <= 1'b0;
            if (accept) begin
                mem_addr <= req_addr[ADDR_W+1:2];
                lane     <= req_addr[1:0];
                funct3_q <= req_funct3;
                strb_q   <= dec_strb;
                if (req_we && dec_err == 2'd0) mem_wdata <= dec_wdata;
                if (dec_err != 2'd0) begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= dec_err;
                end
            end
            if (state == S_RD) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT && wait_cnt != 2'd0) begin
                wait_cnt <= wait_cnt - 2'd1;
            end
            if (state == S_WAIT && wait_cnt == 2'd0) begin
                rsp_rdata <= ld_data;
                rsp_err   <= 2'd0;
            end
            if (state == S_WR) begin
                rsp_rdata <= 32'h0;
                rsp_err   <= 2'd0;
            end
        end
    end

endmodule
